secded_dec: RTL and testbench

//   Parametrised pipelined SECDED Hamming decoder: extended Hamming code (Hamming + overall parity).

---
 rtl/secded_dec_pkg.sv | 40 ++++
 rtl/secded_dec_syndrome.sv | 21 ++
 rtl/secded_dec.sv | 125 ++++++++++++
 tb/tb_secded_dec.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_dec_pkg.sv
// Shared SECDED constants and helpers for the decoder (and its matching encoder).
// par_w() sizes the Hamming parity field, data_pos() maps a data index to its codeword position.
package secded_dec_pkg;

    typedef enum logic [1:0] {
        CLS_CLEAN,
        CLS_CORR,
        CLS_UNCORR
    } cls_e;

    function automatic bit is_pow2(input int unsigned i);
        return (i != 0) && ((i & (i - 1)) == 0);
    endfunction

    // Smallest r with 2^r >= data_w + r + 1 (predicate is monotonic in r).
    function automatic int unsigned par_w(input int unsigned data_w);
        int unsigned r;
        r = 1;
        for (int unsigned t = 1; t < 31; t++) begin
            if ((32'd1 << t) < (data_w + t + 1)) r = t + 1;
        end
        return r;
    endfunction

    // Position of data bit k: the k-th non-power-of-two position counting from 3.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned i = 3; i < k + 64; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_dec_syndrome.sv
// Combinational codeword -> {syndrome, overall parity}; reused by the encoder for parity generation.
module secded_syndrome #(
    parameter int unsigned CW    = 8,
    parameter int unsigned PAR_W = 3
) (
    input  logic [CW-1:0]    cw,
    output logic [PAR_W-1:0] s,
    output logic             p
);

    // Syndrome is the XOR of the positions of all set bits in 1..CW-1.
    always_comb begin
        s = '0;
        for (int unsigned i = 1; i < CW; i++) begin
            if (cw[i]) s = s ^ PAR_W'(i);
        end
    end

    assign p = ^cw;

endmodule

// File: rtl/secded_dec.sv
// Two-stage pipelined SECDED decoder with valid/ready, error flags and saturating counters.
// Build option: SECDED_DEC_POISON_EN forces dout to zero on uncorrectable words.
module secded_dec
    import secded_dec_pkg::*;
#(
    parameter  int unsigned DATA_W = 4,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned PAR_W  = par_w(DATA_W),
    localparam int unsigned CW     = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     ein,
    input  logic              ein_val,
    output logic              ein_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_val,
    input  logic              dout_rdy,
    output logic              err_corr,
    output logic              err_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic                en;
    logic [PAR_W-1:0]    syn_s;
    logic                syn_p;
    logic [DATA_W-1:0]   ein_data;

    logic                s1_val;
    logic [DATA_W-1:0]   s1_data;
    logic [PAR_W-1:0]    s1_s;
    logic                s1_p;

    logic [31:0]         sidx;
    logic                flip;
    cls_e                cls;
    logic [DATA_W-1:0]   data_fix;
    logic [DATA_W-1:0]   dout_n;
    logic                xfer;

    assign en      = !dout_val || dout_rdy;
    assign ein_rdy = en;
    assign xfer    = dout_val && dout_rdy;

    secded_syndrome #(
        .CW    (CW),
        .PAR_W (PAR_W)
    ) u_syndrome (
        .cw (ein),
        .s  (syn_s),
        .p  (syn_p)
    );

    // Stage 1 keeps only the data positions of the codeword: parity positions are
    // fully summarised by s/p, and a flip landing on one leaves the data untouched.
    for (genvar k = 0; k < DATA_W; k++) begin : g_bits
        localparam int unsigned P = data_pos(k);
        assign ein_data[k] = ein[P];
        assign data_fix[k] = s1_data[k] ^ (flip && (sidx == P));
    end

    assign sidx = 32'(s1_s);

    // Classify the stage-1 word from syndrome and overall parity.
    always_comb begin
        cls  = CLS_CLEAN;
        flip = 1'b0;
        if (s1_p) begin
            if (sidx <= CW - 1) begin
                cls  = CLS_CORR;
                flip = (sidx != 0);
            end else begin
                cls = CLS_UNCORR;
            end
        end else if (sidx != 0) begin
            cls = CLS_UNCORR;
        end
    end

    // Select the output data word, optionally poisoning uncorrectable words.
    always_comb begin
`ifdef SECDED_DEC_POISON_EN
        dout_n = (cls == CLS_UNCORR) ? '0 : data_fix;
`else
        dout_n = data_fix;
`endif
    end

    // Both pipeline stages advance together whenever the output is free or being taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_val     <= 1'b0;
            s1_data    <= '0;
            s1_s       <= '0;
            s1_p       <= 1'b0;
            dout_val   <= 1'b0;
            dout       <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else if (en) begin
            s1_val     <= ein_val;
            s1_data    <= ein_data;
            s1_s       <= syn_s;
            s1_p       <= syn_p;
            dout_val   <= s1_val;
            dout       <= dout_n;
            err_corr   <= s1_val && (cls == CLS_CORR);
            err_uncorr <= s1_val && (cls == CLS_UNCORR);
        end
    end

    // Saturating error counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (xfer) begin
            if (err_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + CNT_W'(1);
            if (err_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_dec.sv
// Self-checking bench for secded_dec (DATA_W=4, CNT_W=2): directed vectors plus
// randomized traffic against a scoreboard built from an independent encoder model.
module tb_secded_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ein = '0;
    logic       ein_val = 1'b0;
    logic       ein_rdy;
    logic [3:0] dout;
    logic       dout_val;
    logic       dout_rdy = 1'b0;
    logic       err_corr;
    logic       err_uncorr;
    logic       cnt_clr = 1'b0;
    logic [1:0] corr_cnt;
    logic [1:0] uncorr_cnt;

    secded_dec #(.DATA_W(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ein        (ein),
        .ein_val    (ein_val),
        .ein_rdy    (ein_rdy),
        .dout       (dout),
        .dout_val   (dout_val),
        .dout_rdy   (dout_rdy),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d;
        logic        c;
        logic        u;
        int unsigned acc;
    } exp_t;

    exp_t        q[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    logic [1:0]  m_corr = '0;
    logic [1:0]  m_unc = '0;
    bit          strict_lat = 1'b0;
    bit          prev_stall = 1'b0;
    bit          after_rst = 1'b0;
    bit          last_acc = 1'b0;
    logic [3:0]  prev_dout = '0;
    logic        prev_c = 1'b0;
    logic        prev_u = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit pow2(input int unsigned i);
        return (i & (i - 1)) == 0;
    endfunction

    // Reference encoder: data into non-power-of-two slots, each parity bit 2^j
    // covers positions with bit j set, then position 0 evens out the whole word.
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0]  w;
        int unsigned k;
        logic        par;
        w = '0;
        k = 0;
        for (int unsigned pos = 1; pos < 8; pos++) begin
            if (!pow2(pos)) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int unsigned j = 0; j < 3; j++) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos < 8; pos++)
                if (((pos >> j) & 1) == 1) par = par ^ w[pos];
            w[1 << j] = par;
        end
        w[0] = ^w[7:1];
        return w;
    endfunction

    function automatic logic [3:0] raw(input logic [7:0] w);
        logic [3:0]  d;
        int unsigned k;
        d = '0;
        k = 0;
        for (int unsigned pos = 1; pos < 8; pos++) begin
            if (!pow2(pos)) begin
                d[k] = w[pos];
                k++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mk(input logic [3:0] d, input logic c, input logic u);
        exp_t e;
        e.d = d;
        e.c = c;
        e.u = u;
        e.acc = 0;
        return e;
    endfunction

    // Random word with 0, 1 or 2 distinct bit flips and its expected decode.
    task automatic gen(output logic [7:0] w, output exp_t e);
        logic [3:0]  d;
        int unsigned nf;
        int unsigned b1;
        int unsigned b2;
        d  = 4'($urandom);
        nf = $urandom_range(0, 2);
        b1 = $urandom_range(0, 7);
        w  = enc(d);
        if (nf >= 1) w[b1] = ~w[b1];
        if (nf == 2) begin
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            w[b2] = ~w[b2];
        end
        e = mk(d, nf == 1, nf == 2);
        if (nf == 2) begin
`ifdef SECDED_DEC_POISON_EN
            e.d = 4'h0;
`else
            e.d = raw(w);
`endif
        end
    endtask

    // One clock: drive inputs after the edge, check outputs and step the model mid-cycle.
    task automatic step(input logic v, input logic [7:0] w, input exp_t e,
                        input logic rdy, input logic clr, input logic rstn);
        exp_t g;
        @(posedge clk);
        #1;
        rst = rstn; ein_val = v; ein = w; dout_rdy = rdy; cnt_clr = clr;
        @(negedge clk);
        cyc++;
        last_acc = 1'b0;
        if (after_rst) begin
            chk("rst_dout_val", dout_val, 0);
            chk("rst_ein_rdy", ein_rdy, 1);
            chk("rst_err_corr", err_corr, 0);
            chk("rst_err_uncorr", err_uncorr, 0);
            after_rst = 1'b0;
        end
        chk("corr_cnt", corr_cnt, m_corr);
        chk("uncorr_cnt", uncorr_cnt, m_unc);
        chk("ein_rdy", ein_rdy, !dout_val || rdy);
        if (prev_stall) begin
            chk("hold_val", dout_val, 1);
            chk("hold_dout", dout, prev_dout);
            chk("hold_corr", err_corr, prev_c);
            chk("hold_uncorr", err_uncorr, prev_u);
        end
        if (!rstn) begin
            q.delete();
            m_corr = '0;
            m_unc = '0;
            after_rst = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (dout_val && rdy) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    g = q.pop_front();
                    chk("dout", dout, g.d);
                    chk("err_corr", err_corr, g.c);
                    chk("err_uncorr", err_uncorr, g.u);
                    if (strict_lat) chk("latency", cyc - g.acc, 2);
                    else            chk("latency_min", (cyc - g.acc) >= 2, 1);
                    if (g.c && m_corr != 2'b11) m_corr = m_corr + 2'd1;
                    if (g.u && m_unc != 2'b11)  m_unc  = m_unc + 2'd1;
                end
            end
            if (clr) begin
                m_corr = '0;
                m_unc = '0;
            end
            if (v && ein_rdy) begin
                g = e;
                g.acc = cyc;
                q.push_back(g);
                last_acc = 1'b1;
            end
            prev_stall = dout_val && !rdy;
            prev_dout = dout;
            prev_c = err_corr;
            prev_u = err_uncorr;
        end
    endtask

    task automatic idle(input logic clr);
        step(1'b0, 8'h00, mk(4'h0, 1'b0, 1'b0), 1'b1, clr, 1'b1);
    endtask

    task automatic send(input logic [7:0] w, input exp_t e);
        int unsigned n;
        n = 0;
        do begin
            step(1'b1, w, e, 1'b1, 1'b0, 1'b1);
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) idle(1'b0);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic random_run(input int unsigned n);
        logic [7:0] pw;
        exp_t       pe;
        logic       v;
        gen(pw, pe);
        for (int unsigned i = 0; i < n; i++) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, pw, pe, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, 1'b1);
            if (last_acc) gen(pw, pe);
        end
    endtask

    logic [7:0] bw[6];
    exp_t       be[6];

    initial begin
        int unsigned wi;
        bit          saw_full;
        logic [7:0]  w;
        exp_t        e;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dout_val", dout_val, 0);
        chk("reset_dout", dout, 0);
        chk("reset_err_corr", err_corr, 0);
        chk("reset_err_uncorr", err_uncorr, 0);
        chk("reset_corr_cnt", corr_cnt, 0);
        chk("reset_uncorr_cnt", uncorr_cnt, 0);
        chk("reset_ein_rdy", ein_rdy, 1);

        // Directed vectors with exact latency.
        strict_lat = 1'b1;
        send(8'hAA, mk(4'hB, 1'b0, 1'b0)); drain();
        send(8'h8A, mk(4'hB, 1'b1, 1'b0)); drain();
        send(8'hAB, mk(4'hB, 1'b1, 1'b0)); drain();
`ifdef SECDED_DEC_POISON_EN
        send(8'h82, mk(4'h0, 1'b0, 1'b1)); drain();
`else
        send(8'h82, mk(4'h8, 1'b0, 1'b1)); drain();
`endif

        // Clear on the same cycle as a corrected transfer.
        send(8'h8A, mk(4'hB, 1'b1, 1'b0));
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        chk("clr_wins_corr", corr_cnt, 0);
        chk("clr_wins_uncorr", uncorr_cnt, 0);

        // Five corrected words saturate a 2-bit counter at 3.
        for (int i = 0; i < 5; i++) send(8'h8A, mk(4'hB, 1'b1, 1'b0));
        drain();
        chk("corr_sat", corr_cnt, 3);

        // Backpressure: six words, consumer stalls for three cycles.
        strict_lat = 1'b0;
        for (int i = 0; i < 6; i++) gen(bw[i], be[i]);
        wi = 0;
        saw_full = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (wi < 6) step(1'b1, bw[wi], be[wi], !(n >= 3 && n <= 5), 1'b0, 1'b1);
            else        step(1'b0, 8'h00, mk(4'h0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1);
            if (last_acc) wi++;
            if (!ein_rdy) saw_full = 1'b1;
            if (wi == 6 && q.size() == 0 && n > 6) break;
        end
        chk("bp_all_sent", wi, 6);
        chk("bp_full", saw_full, 1);
        chk("bp_drained", q.size(), 0);

        random_run(400);

        // Reset in the middle of a stream drops everything in flight.
        for (int i = 0; i < 3; i++) begin
            gen(w, e);
            step(1'b1, w, e, 1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 8'hAA, mk(4'hB, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);

        random_run(200);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
